// File: rtl/xif_issue_buffer.sv
// In-order issue buffer for the matrix coprocessor: accepts custom-1 offloads on the
// cv-x-if issue interface, holds them until commit/kill, and forwards committed ones.

package xif_pkg;

  typedef struct packed {
    logic [31:0]      instr;
    logic [1:0]       mode;
    logic [3:0]       id;
    logic [2:0][31:0] rs;
    logic [2:0]       rs_valid;
    logic [5:0]       ecs;
    logic             ecs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic       dualwrite;
    logic [2:0] dualread;
    logic       loadstore;
    logic       ecswrite;
    logic       exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [3:0] id;
    logic       commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic [3:0]       id;
    logic [1:0]       mode;
    logic [2:0][31:0] rs;
    logic [2:0]       rs_valid;
  } offloaded_data_t;

endpackage

module xif_issue_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [6:0]  OPCODE = 7'b0101011
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  xif_pkg::x_issue_req_t          issue_req_i,
  output xif_pkg::x_issue_resp_t         issue_resp_o,
  input  logic                           commit_valid_i,
  input  xif_pkg::x_commit_t             commit_i,
  output logic                           disp_valid_o,
  input  logic                           disp_ready_i,
  output xif_pkg::offloaded_data_t       disp_data_o,
  output logic [$clog2(DEPTH):0]         count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  xif_pkg::offloaded_data_t data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] committed_q;
  logic [DEPTH-1:0] killed_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW:0]      count_q;

  logic          match;
  logic          full;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] scan_idx;
  logic          new_flag;
  logic          unused_ecs;

  assign unused_ecs = ^{issue_req_i.ecs, issue_req_i.ecs_valid};

  assign match = (issue_req_i.instr[6:0] == OPCODE);
  assign full  = (count_q == FULL_COUNT);

  // Non-matching instructions are always answered (with accept=0) so the core never stalls on them.
  assign issue_ready_o = issue_valid_i &
                         (!match | (!full & (issue_req_i.rs_valid[1:0] == 2'b11)));
  assign push          = issue_ready_o & match;

  always_comb begin
    issue_resp_o        = '0;
    issue_resp_o.accept = issue_ready_o & match;
  end

  // Valid entries are contiguous from rd_ptr, so scanning from the head finds the oldest match first.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_q + PW'(k);
      if (!hit && commit_valid_i && valid_q[scan_idx] &&
          !committed_q[scan_idx] && !killed_q[scan_idx] &&
          (data_q[scan_idx].id == commit_i.id)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign new_flag = commit_valid_i & push & !hit & (commit_i.id == issue_req_i.id);

  assign head_valid   = valid_q[rd_ptr_q];
  assign disp_valid_o = head_valid & committed_q[rd_ptr_q];
  assign pop          = head_valid &
                        (killed_q[rd_ptr_q] | (committed_q[rd_ptr_q] & disp_ready_i));
  assign disp_data_o  = disp_valid_o ? data_q[rd_ptr_q] : '0;
  assign count_o      = count_q;

  // A flagged head never matches a commit and push targets a free slot, so the writes below never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (hit) begin
        if (commit_i.commit_kill) begin
          killed_q[hit_idx] <= 1'b1;
        end else begin
          committed_q[hit_idx] <= 1'b1;
        end
      end
      if (pop) begin
        valid_q[rd_ptr_q]     <= 1'b0;
        committed_q[rd_ptr_q] <= 1'b0;
        killed_q[rd_ptr_q]    <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        data_q[wr_ptr_q] <= '{instr:    issue_req_i.instr,
                              id:       issue_req_i.id,
                              mode:     issue_req_i.mode,
                              rs:       issue_req_i.rs,
                              rs_valid: issue_req_i.rs_valid};
        valid_q[wr_ptr_q]     <= 1'b1;
        committed_q[wr_ptr_q] <= new_flag & !commit_i.commit_kill;
        killed_q[wr_ptr_q]    <= new_flag & commit_i.commit_kill;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xif_issue_buffer.sv
// Directed bench for xif_issue_buffer: a table of single-cycle vectors followed by
// hand-written sequences for fill/backpressure, pointer wrap and reset mid-operation.

module tb_xif_issue_buffer;

  logic                      clk_i;
  logic                      rst_i;
  logic                      issue_valid_i;
  logic                      issue_ready_o;
  xif_pkg::x_issue_req_t     issue_req_i;
  xif_pkg::x_issue_resp_t    issue_resp_o;
  logic                      commit_valid_i;
  xif_pkg::x_commit_t        commit_i;
  logic                      disp_valid_o;
  logic                      disp_ready_i;
  xif_pkg::offloaded_data_t  disp_data_o;
  logic [2:0]                count_o;

  int total;
  int bad;

  xif_issue_buffer #(.DEPTH(4), .OPCODE(7'b0101011)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_req_i    (issue_req_i),
    .issue_resp_o   (issue_resp_o),
    .commit_valid_i (commit_valid_i),
    .commit_i       (commit_i),
    .disp_valid_o   (disp_valid_o),
    .disp_ready_i   (disp_ready_i),
    .disp_data_o    (disp_data_o),
    .count_o        (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [6:0]  opc;
    logic [3:0]  id;
    logic [31:0] rs0;
    logic [2:0]  rsv;
    logic        cv;
    logic [3:0]  cid;
    logic        ck;
    logic        rdy;
    logic        e_ready;
    logic        e_acc;
    logic        e_dv;
    logic [3:0]  e_did;
    logic [31:0] e_rs0;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam logic [6:0] MAT = 7'h2B;
  localparam logic [6:0] ALU = 7'h33;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic iv, input logic [6:0] opc, input logic [3:0] id,
                                input logic [31:0] rs0, input logic [2:0] rsv,
                                input logic cv, input logic [3:0] cid, input logic ck,
                                input logic rdy);
    issue_valid_i           = iv;
    issue_req_i             = '0;
    issue_req_i.instr       = {25'h0, opc};
    issue_req_i.id          = id;
    issue_req_i.rs[0]       = rs0;
    issue_req_i.rs[1]       = rs0 + 32'd2;
    issue_req_i.rs_valid    = rsv;
    commit_valid_i          = cv;
    commit_i.id             = cid;
    commit_i.commit_kill    = ck;
    disp_ready_i            = rdy;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, MAT, 4'd0, 32'd0, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_i = 1'b1;
    idle();

    // Vector table: inputs are held for one cycle, combinational outputs checked before the edge.
    vecs[0]  = '{1'b1, MAT, 4'd3, 32'd5,     3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0,     3'd1};
    vecs[1]  = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd1};
    vecs[2]  = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'd5,     3'd0};
    vecs[3]  = '{1'b1, ALU, 4'd6, 32'd0,     3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0,     3'd0};
    vecs[4]  = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd0};
    vecs[5]  = '{1'b1, MAT, 4'd4, 32'h104,   3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd0};
    vecs[6]  = '{1'b1, MAT, 4'd4, 32'h104,   3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0,     3'd1};
    vecs[7]  = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd1};
    vecs[8]  = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd0};
    vecs[9]  = '{1'b1, MAT, 4'd1, 32'h101,   3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0,     3'd1};
    vecs[10] = '{1'b1, MAT, 4'd2, 32'h102,   3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0,     3'd2};
    vecs[11] = '{1'b1, MAT, 4'd3, 32'h103,   3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0,     3'd3};
    vecs[12] = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd3};
    vecs[13] = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd3};
    vecs[14] = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd3};
    vecs[15] = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 32'h101,   3'd2};
    vecs[16] = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,     3'd1};
    vecs[17] = '{1'b0, MAT, 4'd0, 32'd0,     3'b011, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h103,   3'd0};

    tick();
    tick();
    rst_i = 1'b0;
    check_output("reset_count", 32'(count_o), 32'd0);
    check_output("reset_disp_valid", 32'(disp_valid_o), 32'd0);
    check_output("reset_disp_data_id", 32'(disp_data_o.id), 32'd0);
    check_output("reset_disp_data_instr", disp_data_o.instr, 32'd0);

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].iv, vecs[i].opc, vecs[i].id, vecs[i].rs0, vecs[i].rsv,
                     vecs[i].cv, vecs[i].cid, vecs[i].ck, vecs[i].rdy);
      #1;
      check_output($sformatf("v%0d_issue_ready", i), 32'(issue_ready_o), 32'(vecs[i].e_ready));
      check_output($sformatf("v%0d_accept", i), 32'(issue_resp_o.accept), 32'(vecs[i].e_acc));
      check_output($sformatf("v%0d_disp_valid", i), 32'(disp_valid_o), 32'(vecs[i].e_dv));
      if (vecs[i].e_dv) begin
        check_output($sformatf("v%0d_disp_id", i), 32'(disp_data_o.id), 32'(vecs[i].e_did));
        check_output($sformatf("v%0d_disp_rs0", i), disp_data_o.rs[0], vecs[i].e_rs0);
      end
      tick();
      check_output($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].e_cnt));
    end
    idle();

    // Fill all four entries with the dispatcher stalled.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, MAT, 4'(8 + k), 32'h200 + 32'(k), 3'b011, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check_output($sformatf("fill%0d_ready", k), 32'(issue_ready_o), 32'd1);
      tick();
      check_output($sformatf("fill%0d_count", k), 32'(count_o), 32'(k + 1));
    end
    apply_stimulus(1'b1, MAT, 4'd12, 32'h20C, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check_output("full_blocks_match", 32'(issue_ready_o), 32'd0);
    check_output("full_resp_zero", 32'(issue_resp_o), 32'd0);
    apply_stimulus(1'b1, ALU, 4'd13, 32'h0, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check_output("full_passes_nonmatch", 32'(issue_ready_o), 32'd1);
    check_output("full_nonmatch_accept", 32'(issue_resp_o.accept), 32'd0);
    tick();
    check_output("full_count", 32'(count_o), 32'd4);

    apply_stimulus(1'b1, MAT, 4'd12, 32'h20C, 3'b011, 1'b1, 4'd8, 1'b0, 1'b0);
    #1;
    check_output("full_commit_ready", 32'(issue_ready_o), 32'd0);
    tick();
    apply_stimulus(1'b1, MAT, 4'd12, 32'h20C, 3'b011, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    check_output("full_pop_cycle_ready", 32'(issue_ready_o), 32'd0);
    check_output("full_pop_disp_valid", 32'(disp_valid_o), 32'd1);
    check_output("full_pop_disp_id", 32'(disp_data_o.id), 32'd8);
    tick();
    check_output("after_pop_count", 32'(count_o), 32'd3);
    apply_stimulus(1'b1, MAT, 4'd12, 32'h20C, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check_output("after_pop_ready", 32'(issue_ready_o), 32'd1);
    tick();
    check_output("refill_count", 32'(count_o), 32'd4);

    // Drain 9..12 by committing one per cycle with the dispatcher always ready.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, MAT, 4'd0, 32'd0, 3'b011, 1'b1, 4'(9 + k), 1'b0, 1'b1);
      #1;
      if (k > 0) begin
        check_output($sformatf("drain%0d_valid", k), 32'(disp_valid_o), 32'd1);
        check_output($sformatf("drain%0d_id", k), 32'(disp_data_o.id), 32'(8 + k));
      end
      tick();
    end
    apply_stimulus(1'b0, MAT, 4'd0, 32'd0, 3'b011, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    check_output("drain_last_id", 32'(disp_data_o.id), 32'd12);
    tick();
    check_output("drain_count", 32'(count_o), 32'd0);

    // Streaming issue+commit in the same cycle wraps the pointers several times.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, MAT, 4'(i), 32'(i), 3'b011, 1'b1, 4'(i), 1'b0, 1'b1);
      #1;
      check_output($sformatf("sweep%0d_ready", i), 32'(issue_ready_o), 32'd1);
      if (i > 0) begin
        check_output($sformatf("sweep%0d_valid", i), 32'(disp_valid_o), 32'd1);
        check_output($sformatf("sweep%0d_id", i), 32'(disp_data_o.id), 32'(i - 1));
      end
      tick();
    end
    apply_stimulus(1'b0, MAT, 4'd0, 32'd0, 3'b011, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    check_output("sweep_last_id", 32'(disp_data_o.id), 32'd11);
    tick();
    check_output("sweep_count", 32'(count_o), 32'd0);

    // Same-cycle issue and commit of id 5, then a stalled dispatcher, then reset.
    apply_stimulus(1'b1, MAT, 4'd5, 32'h55, 3'b011, 1'b1, 4'd5, 1'b0, 1'b0);
    #1;
    check_output("same_cycle_accept", 32'(issue_resp_o.accept), 32'd1);
    check_output("same_cycle_valid_now", 32'(disp_valid_o), 32'd0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output($sformatf("hold%0d_valid", k), 32'(disp_valid_o), 32'd1);
      check_output($sformatf("hold%0d_id", k), 32'(disp_data_o.id), 32'd5);
      check_output($sformatf("hold%0d_rs0", k), disp_data_o.rs[0], 32'h55);
      check_output($sformatf("hold%0d_rsv", k), 32'(disp_data_o.rs_valid), 32'd3);
      check_output($sformatf("hold%0d_count", k), 32'(count_o), 32'd1);
      tick();
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_output("midrst_valid", 32'(disp_valid_o), 32'd0);
    check_output("midrst_count", 32'(count_o), 32'd0);
    check_output("midrst_data", disp_data_o.rs[0], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xif_issue_buffer.md
Name: xif_issue_buffer

Overview:
- Front end of the matrix coprocessor on the cv-x-if issue and commit interfaces.
- Decodes and accepts offloaded instructions, then buffers them in order in a small FIFO until the core commits or kills each one.
- Forwards committed instructions to the dispatcher as offloaded_data_t. Killed instructions are dropped silently.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, ≥2.
- OPCODE, 7'b0101011, major opcode (instr[6:0]) claimed by the coprocessor (custom-1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  core offers an instruction.
- issue_ready_o  out  1  issue handshake completes this cycle.
- issue_req_i  in  144  xif_pkg::x_issue_req_t.
- issue_resp_o  out  9  xif_pkg::x_issue_resp_t; meaningful only on issue handshake.
- commit_valid_i  in  1  commit/kill strobe.
- commit_i  in  5  xif_pkg::x_commit_t.
- disp_valid_o  out  1  head entry committed and ready for the dispatcher.
- disp_ready_i  in  1  dispatcher accepts.
- disp_data_o  out  137  xif_pkg::offloaded_data_t of the head entry.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset values: all entries invalid; rd/wr pointers 0; count_o=0; disp_valid_o=0; disp_data_o=0. Reset applied mid-operation discards all entries on the next edge, including committed-but-unpopped ones.
- Decode: match = (issue_req_i.instr[6:0]==OPCODE).
- Handshake rule: issue_ready_o = issue_valid_i & (!match | (!full & issue_req_i.rs_valid[1:0]==2'b11)). Combinational; no dependence on commit_i.
- Issue response:
  - accept = match.
  - writeback, dualwrite, dualread, loadstore, ecswrite, exc all = 0.
  - issue_resp_o = 0 whenever issue_ready_o=0.
- Allocation: only on issue_valid_i & issue_ready_o & match. The entry stores instr, id, mode, rs, rs_valid, with flags committed=0 and killed=0. Non-matching instructions are answered accept=0 and not stored.
- Entry storage is flops. disp_data_o is driven directly from the head entry, so there is no combinational path from any input to disp_data_o.
- Commit: on commit_valid_i, find the oldest valid entry with id==commit_i.id and no flag set.
  - commit_kill=0: set committed.
  - commit_kill=1: set killed.
  - No match (non-accepted or unknown id): ignored, no error.
- Same-cycle issue+commit with equal id and no buffered match: the flag is applied to the newly allocated entry.
- Head processing, each cycle:
  - Head valid & killed: pop without asserting disp_valid_o.
  - Head valid & committed: disp_valid_o=1; pop when disp_ready_i=1.
  - Head valid & neither flag: disp_valid_o=0 and wait. Younger committed entries do not bypass the head (strict in-order).
  - At most one pop per cycle.
- disp_valid_o is a registered-state function. Once asserted it holds, with stable disp_data_o, until disp_ready_i.
- Latency: issue and commit in cycle N give disp_valid_o=1 in cycle N+1 at the earliest.
- Full/empty:
  - full = (count_o==DEPTH).
  - Push and pop in the same cycle on a full buffer is not allowed, because issue_ready_o uses the current full.
  - Push+pop otherwise leaves count_o unchanged.
- Pointers are $clog2(DEPTH)-bit and wrap modulo DEPTH.
- disp_data_o.rs_valid mirrors the stored rs_valid.

Test Plan:
- Reset then issue instr=32'h0000_002B, id=3, rs0=5, rs1=7, rs_valid=3'b011 → accept=1, count_o=1, disp_valid_o=0. Commit id=3 kill=0 → next cycle disp_valid_o=1, disp_data_o.id=3, rs[0]=5. disp_ready_i=1 → count_o=0.
- Issue instr opcode 7'b0110011 → issue_ready_o=1, accept=0, count_o unchanged. Commit on that id → no effect.
- Issue ids 1,2,3 in order; kill id 2; commit 3 then 1 → dispatcher sees id 1 then id 3; id 2 never appears.
- Fill 4 entries with disp_ready_i=0 → count_o=4. Fifth matching issue → issue_ready_o=0. After one pop → issue_ready_o=1. Sweep ≥10 issues so the pointers wrap.
- Issue with rs_valid=3'b001 → issue_ready_o=0 until rs_valid[1]=1.
- Same cycle as the issue of id 5, commit id 5 kill=0 → disp_valid_o=1 next cycle. Hold disp_ready_i=0 for 3 cycles → data stable. Assert rst_i → disp_valid_o=0 and count_o=0 the following cycle.
